// File: rtl/simple_isa_pkg.sv
// Purpose: shared SIMPLE ISA field layout, opcode constants, fetch FSM encoding and decode helpers.
// Latency: none; constants and pure combinational functions only.
// Backpressure: not applicable.
package simple_isa_pkg;

  // OP1 field values (bits [15:14])
  localparam logic [1:0] OP1_LD     = 2'b00;
  localparam logic [1:0] OP1_ST     = 2'b01;
  localparam logic [1:0] OP1_IMM_BR = 2'b10;
  localparam logic [1:0] OP1_ALU    = 2'b11;

  // OP3 field values (bits [7:4]) for the ALU/IO group
  localparam logic [3:0] OP3_ADD = 4'b0000;
  localparam logic [3:0] OP3_SUB = 4'b0001;
  localparam logic [3:0] OP3_AND = 4'b0010;
  localparam logic [3:0] OP3_OR  = 4'b0011;
  localparam logic [3:0] OP3_XOR = 4'b0100;
  localparam logic [3:0] OP3_CMP = 4'b0101;
  localparam logic [3:0] OP3_MOV = 4'b0110;
  localparam logic [3:0] OP3_SLL = 4'b1000;
  localparam logic [3:0] OP3_SLR = 4'b1001;
  localparam logic [3:0] OP3_SRL = 4'b1010;
  localparam logic [3:0] OP3_SRA = 4'b1011;
  localparam logic [3:0] OP3_IN  = 4'b1100;
  localparam logic [3:0] OP3_OUT = 4'b1101;
  localparam logic [3:0] OP3_HLT = 4'b1111;

  // Field slice positions inside a 16-bit instruction word
  localparam int OP1_HI = 15;
  localparam int OP1_LO = 14;
  localparam int RS_HI  = 13;
  localparam int RS_LO  = 11;
  localparam int RD_HI  = 10;
  localparam int RD_LO  = 8;
  localparam int D_HI   = 7;
  localparam int D_LO   = 0;
  localparam int OP3_HI = 7;
  localparam int OP3_LO = 4;

  // Fetch FSM state encoding
  localparam logic [1:0] FETCH_ST  = 2'd0;
  localparam logic [1:0] HOLD_ST   = 2'd1;
  localparam logic [1:0] HALTED_ST = 2'd2;

  function automatic logic [1:0] get_op1(input logic [15:0] w);
    return w[OP1_HI:OP1_LO];
  endfunction

  function automatic logic [3:0] get_op3(input logic [15:0] w);
    return w[OP3_HI:OP3_LO];
  endfunction

  function automatic logic [2:0] get_rs(input logic [15:0] w);
    return w[RS_HI:RS_LO];
  endfunction

  function automatic logic [2:0] get_rd(input logic [15:0] w);
    return w[RD_HI:RD_LO];
  endfunction

  function automatic logic [7:0] get_d(input logic [15:0] w);
    return w[D_HI:D_LO];
  endfunction

  // HLT lives in the ALU group; other OP1 groups reuse bits [7:4] as displacement
  function automatic logic is_hlt(input logic [15:0] w);
    return (get_op1(w) == OP1_ALU) && (get_op3(w) == OP3_HLT);
  endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Purpose: owns the PC, fetches one instruction word at a time and offers it as COMMAND.
// Latency: one cycle after mem_ack the word is presented; one instruction in flight, no prefetch.
// Backpressure: COMMAND/pc_next held stable while cmd_valid=1 and cmd_ready=0; no fetch meanwhile.
module instr_fetch_unit
  import simple_isa_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              CLOCK,
  input  logic              RESET,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic [15:0]       COMMAND,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [ADDR_W-1:0] pc_next,
  input  logic              PC_load,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              halted
);

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic              squash;
  logic [ADDR_W-1:0] squash_addr;

  // Wraps modulo 2^ADDR_W with no carry out
  assign pc_inc = pc + {{(ADDR_W-1){1'b0}}, 1'b1};

  // Outputs follow the state; the request address stays on the uncancellable request while it is squashed
  always_comb begin
    mem_req   = !RESET && (state == FETCH_ST);
    mem_addr  = squash ? squash_addr : pc;
    cmd_valid = !RESET && (state == HOLD_ST);
    halted    = !RESET && (state == HALTED_ST);
  end

  // Fetch/hold/halt sequencing, PC ownership and squash bookkeeping
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state       <= FETCH_ST;
      pc          <= RESET_PC;
      squash      <= 1'b0;
      squash_addr <= RESET_PC;
      COMMAND     <= 16'h0000;
      pc_next     <= '0;
    end else begin
      case (state)
        FETCH_ST: begin
          if (PC_load) begin
            pc <= branch_target;
            if (mem_ack) begin
              squash <= 1'b0;
            end else begin
              squash <= 1'b1;
              // Only the first redirect captures the outstanding address
              if (!squash) squash_addr <= pc;
            end
          end else if (mem_ack) begin
            if (squash) begin
              squash <= 1'b0;
            end else begin
              COMMAND <= mem_rdata;
              pc_next <= pc_inc;
              pc      <= pc_inc;
              state   <= HOLD_ST;
            end
          end
        end
        HOLD_ST: begin
          if (PC_load) begin
            pc    <= branch_target;
            state <= FETCH_ST;
          end else if (cmd_ready) begin
            state <= is_hlt(COMMAND) ? HALTED_ST : FETCH_ST;
          end
        end
        HALTED_ST: state <= HALTED_ST;
        default:   state <= FETCH_ST;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Purpose: scoreboard bench for instr_fetch_unit against an instruction-stream reference model.
// Latency: model predicts the ordered stream of transferred words, not cycle timing.
// Backpressure: random cmd_ready and memory ack latency; stability checked while stalled.
module tb_instr_fetch_unit;

  typedef struct packed {
    logic [15:0] cmd;
    logic [15:0] pcn;
  } exp_t;

  logic        CLOCK;
  logic        RESET;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] COMMAND;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] pc_next;
  logic        PC_load;
  logic [15:0] branch_target;
  logic        halted;

  logic        w_mem_req;
  logic [15:0] w_mem_addr;
  logic        w_mem_ack;
  logic [15:0] w_mem_rdata;
  logic [15:0] w_command;
  logic        w_cmd_valid;
  logic        w_cmd_ready;
  logic [15:0] w_pc_next;
  logic        w_pc_load;
  logic [15:0] w_branch_target;
  logic        w_halted;

  int          total = 0;
  int          bad = 0;
  int          xfer_cnt = 0;
  bit          model_halted = 0;
  exp_t        exp_q[$];
  logic [15:0] req_log[$];
  int          lat = 0;
  bit          rand_lat = 0;
  bit          ack_in_reset = 0;
  bit          hlt_en = 0;
  bit          c050_en = 0;
  logic [15:0] hlt_addr = 16'd3;

  instr_fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .COMMAND(COMMAND), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .pc_next(pc_next),
    .PC_load(PC_load), .branch_target(branch_target), .halted(halted)
  );

  // Second instance starting at the top of the address space, always-ready memory and consumer
  assign w_mem_ack       = w_mem_req;
  assign w_mem_rdata     = {1'b0, w_mem_addr[14:0]};
  assign w_cmd_ready     = 1'b1;
  assign w_pc_load       = 1'b0;
  assign w_branch_target = 16'h0000;

  instr_fetch_unit #(.ADDR_W(16), .RESET_PC(16'hFFFF)) u_wrap (
    .CLOCK(CLOCK), .RESET(RESET),
    .mem_req(w_mem_req), .mem_addr(w_mem_addr), .mem_ack(w_mem_ack), .mem_rdata(w_mem_rdata),
    .COMMAND(w_command), .cmd_valid(w_cmd_valid), .cmd_ready(w_cmd_ready), .pc_next(w_pc_next),
    .PC_load(w_pc_load), .branch_target(w_branch_target), .halted(w_halted)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory contents
  function automatic logic [15:0] word(input logic [15:0] a);
    if (hlt_en && a == hlt_addr) return 16'hC0F0;
    if (c050_en && a == 16'h0000) return 16'hC050;
    return {1'b0, a[14:0] ^ 15'h2A5A};
  endfunction

  function automatic bit model_is_hlt(input logic [15:0] w);
    return (w[15:14] == 2'b11) && (w[7:4] == 4'hF);
  endfunction

  function automatic logic [31:0] get_req(input int i);
    if (i < req_log.size()) return {16'h0000, req_log[i]};
    return 32'hDEADBEEF;
  endfunction

  // Reference model: after a reset or redirect the transferred words are the memory words
  // at consecutive addresses from the new PC, ending with the first HLT
  task automatic push_stream(input logic [15:0] start);
    logic [15:0] a;
    exp_t        e;
    exp_q.delete();
    a = start;
    for (int i = 0; i < 300; i++) begin
      e.cmd = word(a);
      e.pcn = a + 16'd1;
      exp_q.push_back(e);
      if (model_is_hlt(e.cmd)) break;
      a = a + 16'd1;
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic do_reset(input bit rdy);
    tick();
    RESET = 1'b1;
    PC_load = 1'b0;
    cmd_ready = rdy;
    exp_q.delete();
    req_log.delete();
    model_halted = 0;
    @(negedge CLOCK);
    check("rst_mem_req", mem_req, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_halted", halted, 0);
    tick();
    RESET = 1'b0;
    ack_in_reset = 0;
    push_stream(16'h0000);
    @(negedge CLOCK);
    check("post_rst_command", COMMAND, 0);
    check("post_rst_pc_next", pc_next, 0);
    check("post_rst_cmd_valid", cmd_valid, 0);
    check("post_rst_halted", halted, 0);
    check("post_rst_mem_req", mem_req, 1);
    check("post_rst_mem_addr", mem_addr, 16'h0000);
  endtask

  task automatic wait_xfers(input int n, input int budget, input string name);
    int start;
    int c;
    start = xfer_cnt;
    c = 0;
    while (xfer_cnt < start + n && c < budget) begin
      tick();
      c++;
    end
    check(name, xfer_cnt - start, n);
  endtask

  // Memory: acks after a per-request latency, logs each new request, checks address hold
  initial begin
    bit          pending;
    int          cnt;
    int          cur_lat;
    logic [15:0] req_addr;
    pending = 0;
    cnt = 0;
    cur_lat = 0;
    req_addr = 16'h0000;
    mem_ack = 1'b0;
    mem_rdata = 16'h0000;
    forever begin
      @(posedge CLOCK);
      #2;
      if (RESET && ack_in_reset) begin
        mem_ack = 1'b1;
        mem_rdata = 16'hC0F0;
        pending = 0;
      end else if (mem_req) begin
        if (!pending) begin
          req_log.push_back(mem_addr);
          req_addr = mem_addr;
          cnt = 0;
          cur_lat = rand_lat ? int'($urandom_range(0, 3)) : lat;
        end else begin
          check("mem_addr_hold", mem_addr, req_addr);
        end
        if (cnt >= cur_lat) begin
          mem_ack = 1'b1;
          mem_rdata = word(mem_addr);
          pending = 0;
        end else begin
          mem_ack = 1'b0;
          mem_rdata = 16'($urandom);
          cnt++;
          pending = 1;
        end
      end else begin
        mem_ack = 1'b0;
        mem_rdata = 16'($urandom);
        pending = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on every transfer and checks handshake invariants
  initial begin
    bit          prev_stall;
    logic [15:0] prev_cmd;
    logic [15:0] prev_pcn;
    exp_t        e;
    prev_stall = 0;
    prev_cmd = 16'h0000;
    prev_pcn = 16'h0000;
    forever begin
      @(negedge CLOCK);
      if (RESET) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", cmd_valid, 1);
          check("stall_command", COMMAND, prev_cmd);
          check("stall_pc_next", pc_next, prev_pcn);
        end
        if (cmd_valid) check("no_prefetch", mem_req, 0);
        if (model_halted) begin
          check("halted_out", halted, 1);
          check("halted_mem_req", mem_req, 0);
          check("halted_cmd_valid", cmd_valid, 0);
        end
        if (cmd_valid && cmd_ready && !PC_load) begin
          xfer_cnt++;
          if (exp_q.size() == 0) begin
            check("unexpected_xfer", {16'h0000, COMMAND}, 32'hFFFFFFFF);
          end else begin
            e = exp_q.pop_front();
            check("xfer_command", COMMAND, e.cmd);
            check("xfer_pc_next", pc_next, e.pcn);
            if (model_is_hlt(e.cmd)) model_halted = 1;
          end
        end
        prev_stall = cmd_valid && !cmd_ready && !PC_load;
        prev_cmd = COMMAND;
        prev_pcn = pc_next;
      end
    end
  end

  initial begin
    int x0;
    int c;
    RESET = 1'b1;
    PC_load = 1'b0;
    cmd_ready = 1'b0;
    branch_target = 16'h0000;

    // Zero-latency memory, always ready: alternating valid, sequential addresses
    lat = 0;
    do_reset(1);
    for (int i = 1; i <= 5; i++) begin
      @(negedge CLOCK);
      check("pulse_valid", cmd_valid, (i % 2 == 1) ? 1 : 0);
      if (i == 1) begin
        check("wrap_valid", w_cmd_valid, 1);
        check("wrap_pc_next", w_pc_next, 16'h0000);
        check("wrap_command", w_command, 16'h7FFF);
      end
      if (i == 2) begin
        check("wrap_mem_req", w_mem_req, 1);
        check("wrap_mem_addr", w_mem_addr, 16'h0000);
      end
    end
    check("seq_addr0", get_req(0), 32'h0000);
    check("seq_addr1", get_req(1), 32'h0001);
    check("seq_addr2", get_req(2), 32'h0002);

    // Backpressure on 16'hC050
    c050_en = 1;
    do_reset(0);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLOCK);
      check("bp_command", COMMAND, 16'hC050);
      check("bp_pc_next", pc_next, 16'h0001);
      check("bp_mem_req", mem_req, 0);
    end
    check("bp_one_fetch", req_log.size(), 1);
    tick();
    cmd_ready = 1'b1;
    wait_xfers(2, 20, "bp_xfers");
    c050_en = 0;

    // Squash: redirect in the second wait cycle of a 3-cycle fetch
    lat = 3;
    do_reset(1);
    tick();
    PC_load = 1'b1;
    branch_target = 16'h0040;
    push_stream(16'h0040);
    tick();
    PC_load = 1'b0;
    @(negedge CLOCK);
    check("sq_mem_req", mem_req, 1);
    check("sq_mem_addr", mem_addr, 16'h0000);
    wait_xfers(1, 30, "sq_xfer");
    check("sq_req0", get_req(0), 32'h0000);
    check("sq_req1", get_req(1), 32'h0040);

    // Redirect in HOLD with cmd_ready=1
    lat = 0;
    do_reset(1);
    tick();
    PC_load = 1'b1;
    branch_target = 16'h0010;
    push_stream(16'h0010);
    x0 = xfer_cnt;
    @(negedge CLOCK);
    check("hr_valid", cmd_valid, 1);
    tick();
    PC_load = 1'b0;
    @(negedge CLOCK);
    check("hr_valid_drop", cmd_valid, 0);
    check("hr_no_xfer", xfer_cnt - x0, 0);
    check("hr_req", get_req(1), 32'h0010);
    wait_xfers(1, 20, "hr_xfer");

    // HLT at address 3
    hlt_en = 1;
    rand_lat = 1;
    do_reset(1);
    x0 = xfer_cnt;
    c = 0;
    while (!model_halted && c < 60) begin
      tick();
      c++;
    end
    check("hlt_reached", model_halted, 1);
    check("hlt_xfers", xfer_cnt - x0, 4);
    PC_load = 1'b1;
    branch_target = 16'h0020;
    tick();
    PC_load = 1'b0;
    for (int i = 0; i < 5; i++) @(negedge CLOCK);
    check("hlt_stays", halted, 1);
    check("hlt_no_more", xfer_cnt - x0, 4);
    hlt_en = 0;
    rand_lat = 0;
    do_reset(1);
    wait_xfers(1, 20, "hlt_restart");

    // Reset during a pending 3-cycle fetch, with a stale HLT ack in the reset cycle
    lat = 3;
    do_reset(1);
    ack_in_reset = 1;
    do_reset(1);
    wait_xfers(1, 20, "mid_rst_xfer");
    check("mid_rst_halted", halted, 0);

    // Random redirects, backpressure and ack latency
    rand_lat = 1;
    do_reset(1);
    for (int i = 0; i < 600; i++) begin
      tick();
      cmd_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) begin
        PC_load = 1'b1;
        branch_target = ($urandom_range(0, 3) == 0) ? (16'hFFFC + 16'($urandom_range(0, 3)))
                                                    : 16'($urandom_range(0, 65535));
        if (!model_halted) push_stream(branch_target);
      end else begin
        PC_load = 1'b0;
      end
    end
    tick();
    PC_load = 1'b0;
    cmd_ready = 1'b1;
    wait_xfers(2, 40, "drain_xfers");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
